// File: rtl/fetch_redirect_if.sv
// Fetch-unit bundle: instruction memory request/response channels plus the
// decode-side instruction stream and redirect inputs.
interface fetch_redirect_if #(
   parameter int p_addr_bits = 32,
   parameter int p_inst_bits = 32,
   parameter int p_opaq_bits = 8
);
   // memory request (op: 0 = READ)
   logic                   mem_req_val;
   logic                   mem_req_rdy;
   logic                   mem_req_op;
   logic [p_opaq_bits-1:0] mem_req_opaque;
   logic [p_addr_bits-1:0] mem_req_addr;
   logic [1:0]             mem_req_len;
   logic [p_inst_bits-1:0] mem_req_data;

   // memory response
   logic                   mem_resp_val;
   logic                   mem_resp_rdy;
   logic                   mem_resp_op;
   logic [p_opaq_bits-1:0] mem_resp_opaque;
   logic [p_addr_bits-1:0] mem_resp_addr;
   logic [1:0]             mem_resp_len;
   logic [p_inst_bits-1:0] mem_resp_data;

   // decode side
   logic                   d_val;
   logic                   d_rdy;
   logic [p_inst_bits-1:0] d_inst;
   logic [p_addr_bits-1:0] d_pc;
   logic                   d_squash;
   logic [p_addr_bits-1:0] d_branch_target;

   modport master (
      output mem_req_val, mem_req_op, mem_req_opaque, mem_req_addr, mem_req_len, mem_req_data,
      input  mem_req_rdy,
      input  mem_resp_val, mem_resp_op, mem_resp_opaque, mem_resp_addr, mem_resp_len, mem_resp_data,
      output mem_resp_rdy,
      output d_val, d_inst, d_pc,
      input  d_rdy, d_squash, d_branch_target
   );

   modport slave (
      input  mem_req_val, mem_req_op, mem_req_opaque, mem_req_addr, mem_req_len, mem_req_data,
      output mem_req_rdy,
      output mem_resp_val, mem_resp_op, mem_resp_opaque, mem_resp_addr, mem_resp_len, mem_resp_data,
      input  mem_resp_rdy,
      input  d_val, d_inst, d_pc,
      output d_rdy, d_squash, d_branch_target
   );
endinterface

// File: rtl/fetch_redirect.sv
// Sequential instruction fetch with bounded outstanding reads and same-cycle
// redirect. Each request carries the fetch epoch in its opaque field; a squash
// bumps the epoch so responses to older requests are recognised and discarded.
module fetch_redirect #(
   parameter int                     p_addr_bits     = 32,
   parameter logic [p_addr_bits-1:0] p_rst_addr      = '0,
   parameter int                     p_inst_bits     = 32,
   parameter int                     p_opaq_bits     = 8,
   parameter int                     p_max_in_flight = 4
) (
   input logic               clk,
   input logic               rst,
   fetch_redirect_if.master  io
);

   localparam int                     c_cnt_bits = $clog2(p_max_in_flight + 1);
   localparam logic [c_cnt_bits-1:0]  c_max      = c_cnt_bits'(p_max_in_flight);
   localparam logic [c_cnt_bits-1:0]  c_cnt_one  = c_cnt_bits'(1);
   localparam logic [p_addr_bits-1:0] c_inc      = p_addr_bits'(4);
   localparam logic [p_opaq_bits-1:0] c_ep_one   = p_opaq_bits'(1);

   logic [p_addr_bits-1:0] curr_addr_q, curr_addr_d;
   logic [p_opaq_bits-1:0] epoch_q, epoch_d;
   logic [c_cnt_bits-1:0]  num_in_flight_q, num_in_flight_d;

   logic [p_addr_bits-1:0] ea;
   logic [p_opaq_bits-1:0] ee;
   logic                   drop;
   logic                   req_xfer;
   logic                   resp_xfer;

   // op and len of a response carry nothing this unit needs
   logic unused_resp_fields;
   assign unused_resp_fields = ^{io.mem_resp_op, io.mem_resp_len};

   // Request and response paths: purely combinational, a squash steers the
   // request issued in the same cycle and kills any response arriving with it.
   always_comb begin
      ea   = io.d_squash ? io.d_branch_target : curr_addr_q;
      ee   = io.d_squash ? (epoch_q + c_ep_one) : epoch_q;
      drop = io.mem_resp_val && ((io.mem_resp_opaque != ee) || io.d_squash);

      io.mem_req_val    = !rst && (num_in_flight_q < c_max);
      io.mem_req_op     = 1'b0;
      io.mem_req_opaque = ee;
      io.mem_req_addr   = ea;
      io.mem_req_len    = '0;
      io.mem_req_data   = '0;

      io.mem_resp_rdy   = !rst && (io.d_rdy || drop);
      io.d_val          = !rst && io.mem_resp_val && !drop;
      io.d_inst         = io.mem_resp_data;
      io.d_pc           = io.mem_resp_addr;
   end

   // Next-state: fetch pointer, epoch and outstanding-request count.
   always_comb begin
      req_xfer        = io.mem_req_val && io.mem_req_rdy;
      resp_xfer       = io.mem_resp_val && io.mem_resp_rdy;
      curr_addr_d     = curr_addr_q;
      epoch_d         = ee;
      num_in_flight_d = num_in_flight_q;

      if (req_xfer) begin
         curr_addr_d = ea + c_inc;
      end else if (io.d_squash) begin
         curr_addr_d = io.d_branch_target;
      end

      // a freed slot is only visible next cycle; simultaneous xfers cancel
      case ({req_xfer, resp_xfer})
         2'b10:   num_in_flight_d = num_in_flight_q + c_cnt_one;
         2'b01:   num_in_flight_d = num_in_flight_q - c_cnt_one;
         default: num_in_flight_d = num_in_flight_q;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         curr_addr_q     <= p_rst_addr;
         epoch_q         <= '0;
         num_in_flight_q <= '0;
      end else begin
         curr_addr_q     <= curr_addr_d;
         epoch_q         <= epoch_d;
         num_in_flight_q <= num_in_flight_d;
      end
   end

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: in-order memory model with configurable latency,
// directed scenarios, then randomized traffic against a generation-based model.
module tb_fetch_redirect;
   localparam int AW   = 32;
   localparam int IW   = 32;
   localparam int OW   = 8;
   localparam int MAXF = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_redirect_if #(.p_addr_bits(AW), .p_inst_bits(IW), .p_opaq_bits(OW)) io ();

   fetch_redirect #(
      .p_addr_bits(AW), .p_rst_addr(32'h0), .p_inst_bits(IW),
      .p_opaq_bits(OW), .p_max_in_flight(MAXF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io (io)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [OW-1:0] opq;
      int            t;
      int            gen;
   } mreq_t;

   mreq_t memq[$];
   int    cyc      = 0;
   int    lat      = 2;
   int    sq_cnt   = 0;
   bit    mem_hold = 1'b0;
   bit    mem_gate = 1'b1;

   function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
   endfunction

   task automatic drive_mem();
      io.mem_resp_op  = 1'b0;
      io.mem_resp_len = 2'd0;
      if (memq.size() > 0 && !mem_hold && mem_gate && (cyc - memq[0].t >= lat)) begin
         io.mem_resp_val    = 1'b1;
         io.mem_resp_opaque = memq[0].opq;
         io.mem_resp_addr   = memq[0].addr;
         io.mem_resp_data   = inst_of(memq[0].addr);
      end else begin
         io.mem_resp_val    = 1'b0;
         io.mem_resp_opaque = '0;
         io.mem_resp_addr   = '0;
         io.mem_resp_data   = '0;
      end
   endtask

   task automatic settle();
      drive_mem();
      #1;
   endtask

   // record this cycle's handshakes in the memory model, then advance a cycle
   task automatic tick();
      mreq_t e;
      if (rst) begin
         memq.delete();
         sq_cnt = 0;
      end else begin
         if (io.mem_resp_val && io.mem_resp_rdy) void'(memq.pop_front());
         if (io.mem_req_val && io.mem_req_rdy) begin
            e.addr = io.mem_req_addr;
            e.opq  = io.mem_req_opaque;
            e.t    = cyc;
            e.gen  = sq_cnt + (io.d_squash ? 1 : 0);
            memq.push_back(e);
         end
         if (io.d_squash) sq_cnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_mem();
      #1;
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      io.d_squash        = 1'b0;
      io.d_branch_target = '0;
      io.mem_req_rdy     = 1'b0;
      io.d_rdy           = 1'b0;
      mem_hold           = 1'b0;
      mem_gate           = 1'b1;
      lat                = 2;
      tick();
      tick();
      rst = 1'b0;
      settle();
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      io.d_rdy       = 1'b1;
      io.mem_req_rdy = 1'b1;
      settle();
      checks++; if (io.mem_req_val !== 1'b0) begin errors++; $display("FAIL reset_req_val: got %0b want 0", io.mem_req_val); end
      checks++; if (io.mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy: got %0b want 0", io.mem_resp_rdy); end
      checks++; if (io.d_val !== 1'b0) begin errors++; $display("FAIL reset_d_val: got %0b want 0", io.d_val); end
      tick();
      tick();
      rst = 1'b0;
      settle();
      checks++; if (io.mem_req_val !== 1'b1) begin errors++; $display("FAIL first_req_val: got %0b want 1", io.mem_req_val); end
      checks++; if (io.mem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %0h want 0", io.mem_req_addr); end
      checks++; if (io.mem_req_opaque !== 8'h0) begin errors++; $display("FAIL first_req_opaque: got %0h want 0", io.mem_req_opaque); end
   endtask

   task automatic test_stream();
      logic [AW-1:0] exp_req = 32'h0;
      logic [AW-1:0] exp_pc  = 32'h0;
      int            ndeliv  = 0;
      do_reset();
      io.mem_req_rdy = 1'b1;
      io.d_rdy       = 1'b1;
      settle();
      for (int i = 0; i < 24; i++) begin
         checks++; if (io.mem_req_val !== 1'b1) begin errors++; $display("FAIL stream_req_val: got %0b want 1", io.mem_req_val); end
         checks++; if (io.mem_req_addr !== exp_req) begin errors++; $display("FAIL stream_req_addr: got %0h want %0h", io.mem_req_addr, exp_req); end
         checks++; if (io.mem_req_opaque !== 8'h0) begin errors++; $display("FAIL stream_req_opaque: got %0h want 0", io.mem_req_opaque); end
         exp_req += 4;
         if (io.d_val) begin
            checks++; if (io.d_pc !== exp_pc) begin errors++; $display("FAIL stream_pc: got %0h want %0h", io.d_pc, exp_pc); end
            checks++; if (io.d_inst !== inst_of(exp_pc)) begin errors++; $display("FAIL stream_inst: got %0h want %0h", io.d_inst, inst_of(exp_pc)); end
            exp_pc += 4;
            ndeliv++;
         end
         tick();
      end
      checks++; if (ndeliv != 22) begin errors++; $display("FAIL stream_count: got %0d want 22", ndeliv); end
   endtask

   task automatic test_limit();
      int nx = 0;
      do_reset();
      mem_hold       = 1'b1;
      io.mem_req_rdy = 1'b1;
      io.d_rdy       = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle();
         if (io.mem_req_val) begin
            checks++; if (io.mem_req_addr !== 32'(4 * nx)) begin errors++; $display("FAIL limit_addr: got %0h want %0h", io.mem_req_addr, 4 * nx); end
            nx++;
         end
         tick();
      end
      checks++; if (nx != MAXF) begin errors++; $display("FAIL limit_count: got %0d want %0d", nx, MAXF); end
      settle();
      checks++; if (io.mem_req_val !== 1'b0) begin errors++; $display("FAIL limit_full: got %0b want 0", io.mem_req_val); end
      mem_hold = 1'b0;
      settle();
      checks++; if (io.d_val !== 1'b1) begin errors++; $display("FAIL limit_resp_dval: got %0b want 1", io.d_val); end
      checks++; if (io.mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL limit_resp_rdy: got %0b want 1", io.mem_resp_rdy); end
      checks++; if (io.mem_req_val !== 1'b0) begin errors++; $display("FAIL limit_no_bypass: got %0b want 0", io.mem_req_val); end
      mem_hold = 1'b1;
      tick();
      checks++; if (io.mem_req_val !== 1'b1) begin errors++; $display("FAIL limit_slot_freed: got %0b want 1", io.mem_req_val); end
      checks++; if (io.mem_req_addr !== 32'h10) begin errors++; $display("FAIL limit_next_addr: got %0h want 10", io.mem_req_addr); end
      tick();
      checks++; if (io.mem_req_val !== 1'b0) begin errors++; $display("FAIL limit_refull: got %0b want 0", io.mem_req_val); end
   endtask

   task automatic test_squash();
      int ndrop = 0;
      int got   = 0;
      do_reset();
      mem_hold       = 1'b1;
      io.mem_req_rdy = 1'b1;
      io.d_rdy       = 1'b1;
      tick(); tick(); tick();
      io.d_squash        = 1'b1;
      io.d_branch_target = 32'h100;
      settle();
      checks++; if (io.mem_req_val !== 1'b1) begin errors++; $display("FAIL squash_req_val: got %0b want 1", io.mem_req_val); end
      checks++; if (io.mem_req_addr !== 32'h100) begin errors++; $display("FAIL squash_req_addr: got %0h want 100", io.mem_req_addr); end
      checks++; if (io.mem_req_opaque !== 8'h1) begin errors++; $display("FAIL squash_req_opaque: got %0h want 1", io.mem_req_opaque); end
      tick();
      io.d_squash    = 1'b0;
      io.mem_req_rdy = 1'b0;
      mem_hold       = 1'b0;
      for (int i = 0; i < 12; i++) begin
         settle();
         if (io.mem_resp_val) begin
            if (io.mem_resp_addr != 32'h100) begin
               checks++; if (io.mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL squash_drop_rdy: got %0b want 1", io.mem_resp_rdy); end
               checks++; if (io.d_val !== 1'b0) begin errors++; $display("FAIL squash_drop_dval: got %0b want 0", io.d_val); end
               ndrop++;
            end else begin
               checks++; if (io.d_val !== 1'b1) begin errors++; $display("FAIL squash_new_dval: got %0b want 1", io.d_val); end
               checks++; if (io.d_pc !== 32'h100) begin errors++; $display("FAIL squash_new_pc: got %0h want 100", io.d_pc); end
               got++;
            end
         end
         tick();
      end
      checks++; if (ndrop != 3) begin errors++; $display("FAIL squash_ndrop: got %0d want 3", ndrop); end
      checks++; if (got != 1) begin errors++; $display("FAIL squash_delivered: got %0d want 1", got); end
   endtask

   task automatic test_squash_stall();
      do_reset();
      io.mem_req_rdy     = 1'b0;
      io.d_squash        = 1'b1;
      io.d_branch_target = 32'h200;
      settle();
      checks++; if (io.mem_req_addr !== 32'h200) begin errors++; $display("FAIL stall_sq_addr: got %0h want 200", io.mem_req_addr); end
      tick();
      io.d_squash    = 1'b0;
      io.mem_req_rdy = 1'b1;
      settle();
      checks++; if (io.mem_req_addr !== 32'h200) begin errors++; $display("FAIL stall_next_addr: got %0h want 200", io.mem_req_addr); end
      checks++; if (io.mem_req_opaque !== 8'h1) begin errors++; $display("FAIL stall_next_opaque: got %0h want 1", io.mem_req_opaque); end
      tick();
      checks++; if (io.mem_req_addr !== 32'h204) begin errors++; $display("FAIL stall_after_addr: got %0h want 204", io.mem_req_addr); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mem_hold       = 1'b1;
      io.mem_req_rdy = 1'b1;
      tick(); tick(); tick();
      io.mem_req_rdy = 1'b0;
      io.d_rdy       = 1'b0;
      mem_hold       = 1'b0;
      settle();
      checks++; if (io.mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL bp_resp_rdy: got %0b want 0", io.mem_resp_rdy); end
      checks++; if (io.d_val !== 1'b1) begin errors++; $display("FAIL bp_dval: got %0b want 1", io.d_val); end
      tick();
      io.d_rdy       = 1'b1;
      io.mem_req_rdy = 1'b1;
      settle();
      checks++; if (io.mem_req_val !== 1'b1) begin errors++; $display("FAIL bp_hold_req_val: got %0b want 1", io.mem_req_val); end
      checks++; if (io.mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL b2b_resp_rdy: got %0b want 1", io.mem_resp_rdy); end
      mem_hold = 1'b1;
      tick();
      io.d_rdy = 1'b0;
      settle();
      checks++; if (io.mem_req_val !== 1'b1) begin errors++; $display("FAIL b2b_count_kept: got %0b want 1", io.mem_req_val); end
      tick();
      checks++; if (io.mem_req_val !== 1'b0) begin errors++; $display("FAIL b2b_count_full: got %0b want 0", io.mem_req_val); end
   endtask

   task automatic test_wrap();
      do_reset();
      io.mem_req_rdy = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         io.d_squash        = 1'b1;
         io.d_branch_target = 32'(k * 16);
         settle();
         checks++; if (io.mem_req_opaque !== OW'(k)) begin errors++; $display("FAIL epoch_wrap_sq: got %0h want %0h", io.mem_req_opaque, OW'(k)); end
         tick();
      end
      io.d_squash = 1'b0;
      settle();
      checks++; if (io.mem_req_opaque !== 8'h0) begin errors++; $display("FAIL epoch_wrap_hold: got %0h want 0", io.mem_req_opaque); end
      io.mem_req_rdy     = 1'b1;
      io.d_squash        = 1'b1;
      io.d_branch_target = 32'hFFFF_FFFC;
      settle();
      checks++; if (io.mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL addr_wrap_sq: got %0h want fffffffc", io.mem_req_addr); end
      tick();
      io.d_squash = 1'b0;
      settle();
      checks++; if (io.mem_req_addr !== 32'h0) begin errors++; $display("FAIL addr_wrap_next: got %0h want 0", io.mem_req_addr); end
      checks++; if (io.mem_req_opaque !== 8'h1) begin errors++; $display("FAIL addr_wrap_opaque: got %0h want 1", io.mem_req_opaque); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      io.mem_req_rdy = 1'b1;
      io.d_rdy       = 1'b1;
      for (int i = 0; i < 6; i++) begin
         io.d_squash        = (i == 3);
         io.d_branch_target = 32'h400;
         settle();
         tick();
      end
      io.d_squash = 1'b0;
      rst         = 1'b1;
      settle();
      checks++; if (io.mem_req_val !== 1'b0) begin errors++; $display("FAIL midrst_req_val: got %0b want 0", io.mem_req_val); end
      checks++; if (io.mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL midrst_resp_rdy: got %0b want 0", io.mem_resp_rdy); end
      checks++; if (io.d_val !== 1'b0) begin errors++; $display("FAIL midrst_dval: got %0b want 0", io.d_val); end
      tick();
      rst = 1'b0;
      settle();
      checks++; if (io.mem_req_val !== 1'b1) begin errors++; $display("FAIL midrst_next_val: got %0b want 1", io.mem_req_val); end
      checks++; if (io.mem_req_addr !== 32'h0) begin errors++; $display("FAIL midrst_next_addr: got %0h want 0", io.mem_req_addr); end
      checks++; if (io.mem_req_opaque !== 8'h0) begin errors++; $display("FAIL midrst_next_opaque: got %0h want 0", io.mem_req_opaque); end
   endtask

   // Reference: the next sequential PC and a squash generation count. A
   // response is stale when its request was issued in an older generation.
   task automatic test_random();
      logic [AW-1:0] m_pc = 32'h0;
      logic [OW-1:0] m_ep = '0;
      logic [AW-1:0] exp_addr;
      logic [OW-1:0] exp_opq;
      logic          exp_rv, exp_dv, exp_rr, stale;
      do_reset();
      lat = int'($urandom_range(0, 3));
      for (int i = 0; i < 3000; i++) begin
         io.mem_req_rdy     = ($urandom % 4) != 0;
         io.d_rdy           = ($urandom % 4) != 0;
         mem_gate           = ($urandom % 3) != 0;
         io.d_squash        = ($urandom % 16) == 0;
         io.d_branch_target = $urandom & 32'hFFFF_FFFC;
         settle();
         exp_rv   = memq.size() < MAXF;
         exp_addr = io.d_squash ? io.d_branch_target : m_pc;
         exp_opq  = io.d_squash ? m_ep + 8'd1 : m_ep;
         stale    = 1'b0;
         if (io.mem_resp_val) stale = io.d_squash || (memq[0].gen != sq_cnt);
         exp_dv = io.mem_resp_val && !stale;
         exp_rr = io.d_rdy || stale;
         checks++; if (io.mem_req_val !== exp_rv) begin errors++; $display("FAIL rnd_req_val @%0d: got %0b want %0b", i, io.mem_req_val, exp_rv); end
         checks++; if (io.mem_req_addr !== exp_addr) begin errors++; $display("FAIL rnd_req_addr @%0d: got %0h want %0h", i, io.mem_req_addr, exp_addr); end
         checks++; if (io.mem_req_opaque !== exp_opq) begin errors++; $display("FAIL rnd_req_opaque @%0d: got %0h want %0h", i, io.mem_req_opaque, exp_opq); end
         checks++; if (io.d_val !== exp_dv) begin errors++; $display("FAIL rnd_dval @%0d: got %0b want %0b", i, io.d_val, exp_dv); end
         checks++; if (io.mem_resp_rdy !== exp_rr) begin errors++; $display("FAIL rnd_resp_rdy @%0d: got %0b want %0b", i, io.mem_resp_rdy, exp_rr); end
         if (exp_dv) begin
            checks++; if (io.d_pc !== memq[0].addr) begin errors++; $display("FAIL rnd_pc @%0d: got %0h want %0h", i, io.d_pc, memq[0].addr); end
            checks++; if (io.d_inst !== inst_of(memq[0].addr)) begin errors++; $display("FAIL rnd_inst @%0d: got %0h want %0h", i, io.d_inst, inst_of(memq[0].addr)); end
         end
         if (exp_rv && io.mem_req_rdy) m_pc = exp_addr + 32'd4;
         else if (io.d_squash)        m_pc = io.d_branch_target;
         m_ep = exp_opq;
         tick();
      end
      io.d_squash = 1'b0;
   endtask

   initial begin
      io.mem_req_rdy     = 1'b0;
      io.d_rdy           = 1'b0;
      io.d_squash        = 1'b0;
      io.d_branch_target = '0;
      drive_mem();
      test_reset();
      test_stream();
      test_limit();
      test_squash();
      test_squash_stall();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_redirect.md
# fetch_redirect

Parametrised fetch unit with control-flow redirect. Streams sequential instruction reads to memory with a bounded, configurable number of outstanding requests. On a squash from decode it redirects to a branch target in the same cycle. Responses to pre-squash requests are discarded using an epoch tag carried in the memory opaque field. It sits between the instruction memory port and decode.

## Interface
- p_rst_addr, 32'h0: first fetch address after reset
- p_addr_bits, 32: address / PC width
- p_inst_bits, 32: instruction width
- p_opaq_bits, 8: epoch width carried in opaque (>=1)
- p_max_in_flight, 4: max outstanding requests (1..2**p_opaq_bits)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- mem.req_val  out  1  request valid
- mem.req_rdy  in  1  request ready
- mem.req_msg  out  op/opaque/addr/len/data  op=READ, opaque=epoch, addr=p_addr_bits, len=0, data=0
- mem.resp_val  in  1  response valid
- mem.resp_rdy  out  1  response ready
- mem.resp_msg  in  op/opaque/addr/len/data  only opaque, addr and data are used
- D.val  out  1  instruction valid to decode
- D.rdy  in  1  decode ready
- D.inst  out  p_inst_bits  = mem.resp_msg.data
- D.pc  out  p_addr_bits  = mem.resp_msg.addr
- D.squash  in  1  redirect request, single-cycle pulse, may repeat
- D.branch_target  in  p_addr_bits  redirect address, valid when D.squash=1

## Operation
- State: curr_addr (p_addr_bits), epoch (p_opaq_bits), num_in_flight ($clog2(p_max_in_flight+1) bits).
- Effective address: ea = D.squash ? D.branch_target : curr_addr.
- Effective epoch: ee = D.squash ? epoch+1 : epoch, modulo 2**p_opaq_bits.
- mem.req_msg.addr = ea; mem.req_msg.opaque = ee.
- mem.req_val = !rst && (num_in_flight < p_max_in_flight).
- A slot freed by a same-cycle response does not enable a request; there is no bypass.
- Address update:
  - req xfer: curr_addr <= ea + 4, wrapping at 2**p_addr_bits.
  - else if D.squash: curr_addr <= D.branch_target.
  - else: curr_addr holds.
- Epoch update: D.squash → epoch <= epoch+1, wrapping modulo 2**p_opaq_bits.
- In-flight counter:
  - +1 on req xfer only; −1 on resp xfer only; unchanged when both or neither occur.
  - Dropped responses count as resp xfers.
- Drop rule: drop = mem.resp_val && (resp_msg.opaque != ee || D.squash).
  - A response arriving in the squash cycle is always dropped.
- Response handshake:
  - mem.resp_rdy = !rst && (D.rdy || drop).
  - D.val = !rst && mem.resp_val && !drop.
- Memory is required to return responses in order.
- Epoch aliasing constraint: no request may remain outstanding across 2**p_opaq_bits squashes.
- Reset outputs: mem.req_val=0, mem.resp_rdy=0, D.val=0. State resets to curr_addr=p_rst_addr, epoch=0, num_in_flight=0.
- Reset mid-operation clears all state. Memory must be reset in the same cycle; late responses are not tolerated.

## Timing
- Request path (state, D.squash, D.branch_target → mem.req_*) is combinational, zero cycles. A squash redirects the request issued in that same cycle.
- Response path (mem.resp_* and D.rdy → D.*, mem.resp_rdy) is combinational; no buffering.
- First request: cycle after rst falls, addr=p_rst_addr, opaque=0.
- Throughput: one request per cycle while under the limit. With zero-latency memory the limit is never reached.
- The counter saturates logically at p_max_in_flight; req_val deasserts, so no overflow occurs. No underflow occurs under the in-order memory contract.

## Test plan
- Reset/stream: release rst, req_rdy=1, memory latency 2 → requests at 0x0,0x4,0x8…, all opaque 0. D receives pc 0x0,0x4,… with matching inst, in order.
- Limit: p_max_in_flight=4, memory withholds responses → exactly 4 req xfers (0x0..0xC), then req_val=0. One response returns → req_val=1 the following cycle, not the same cycle.
- Squash: 3 requests outstanding (0x0..0x8, epoch 0), D.squash with target 0x100 → same-cycle request addr 0x100, opaque 1. Three stale responses are dropped with resp_rdy=1, D.val=0. The response for 0x100 is delivered.
- Squash with req_rdy=0: target 0x200 → curr_addr=0x200. The next accepted request is 0x200, opaque 1.
- Backpressure/simultaneous: D.rdy=0 with a valid current-epoch response → resp_rdy=0, counter holds. Assert resp xfer and req xfer together → counter unchanged.
- Epoch wrap: p_opaq_bits=1, two squashes → opaque 0→1→0. Address wrap: branch_target=0xFFFFFFFC → next request 0x0. Reset asserted mid-stream → all outputs 0; next request 0x0, opaque 0.
